// File: rtl/gelato_fetch_scheduler.sv
// Fetch scheduler: round-robin pick of an eligible warp from the PC table, registered
// valid/ready fetch request, and per-warp in-flight masking until decode releases the warp.
module gelato_fetch_scheduler #(
  parameter int unsigned WARP_NUM        = 4,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned SPLIT_NUM_WIDTH = 3,
  parameter int unsigned WARP_ID_WIDTH   = $clog2(WARP_NUM)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      rdy,
  input  logic [WARP_NUM-1:0]                       pct_valid,
  input  logic [WARP_NUM-1:0][PC_WIDTH-1:0]         pct_pc,
  input  logic [WARP_NUM-1:0][SPLIT_NUM_WIDTH-1:0]  pct_split_num,
  output logic                                      fetch_valid,
  input  logic                                      fetch_ready,
  output logic [WARP_ID_WIDTH-1:0]                  fetch_warp_id,
  output logic [PC_WIDTH-1:0]                       fetch_pc,
  output logic [SPLIT_NUM_WIDTH-1:0]                fetch_split_num,
  input  logic                                      release_valid,
  input  logic [WARP_ID_WIDTH-1:0]                  release_warp_id,
  output logic [WARP_NUM-1:0]                       inflight,
  output logic [31:0]                               fetch_count
);

  typedef enum logic {StEmpty, StHold} state_e;

  state_e                     state_q, state_d;
  logic [WARP_ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WARP_ID_WIDTH-1:0]   id_q, id_d;
  logic [PC_WIDTH-1:0]        pc_q, pc_d;
  logic [SPLIT_NUM_WIDTH-1:0] split_q, split_d;
  logic [WARP_NUM-1:0]        inflight_q, inflight_d;
  logic [31:0]                count_q, count_d;

  logic [WARP_NUM-1:0]        elig;
  logic                       any_elig;
  logic [WARP_ID_WIDTH-1:0]   winner;
  logic [WARP_ID_WIDTH-1:0]   idx;
  logic                       fire;
  logic                       load;

  assign elig     = pct_valid & ~inflight_q;
  assign any_elig = |elig;

  // Scan from the farthest offset down so the nearest eligible warp after rr_ptr wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = WARP_NUM; k >= 1; k--) begin
      idx = rr_ptr_q + WARP_ID_WIDTH'(k);
      if (elig[idx]) winner = idx;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    pc_d       = pc_q;
    split_d    = split_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    fire       = 1'b0;
    load       = 1'b0;
    if (rdy) begin
      fire = (state_q == StHold) && fetch_ready;
      load = ((state_q == StEmpty) || fetch_ready) && any_elig;
      if (release_valid) inflight_d[release_warp_id] = 1'b0;
      if (fire) count_d = count_q + 32'd1;
      // A selection after the release clear lets the set win on the same bit.
      if (load) begin
        state_d            = StHold;
        id_d               = winner;
        pc_d               = pct_pc[winner];
        split_d            = pct_split_num[winner];
        inflight_d[winner] = 1'b1;
        rr_ptr_d           = winner;
      end else if (fire) begin
        state_d = StEmpty;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      rr_ptr_q   <= WARP_ID_WIDTH'(WARP_NUM - 1);
      id_q       <= '0;
      pc_q       <= '0;
      split_q    <= '0;
      inflight_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      pc_q       <= pc_d;
      split_q    <= split_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  assign fetch_valid     = (state_q == StHold);
  assign fetch_warp_id   = id_q;
  assign fetch_pc        = pc_q;
  assign fetch_split_num = split_q;
  assign inflight        = inflight_q;
  assign fetch_count     = count_q;

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Directed bench for gelato_fetch_scheduler: inputs change and outputs are sampled on the
// falling edge, the design acts on the rising edge.
module tb_gelato_fetch_scheduler;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy;
  logic [3:0]       pct_valid;
  logic [3:0][31:0] pct_pc;
  logic [3:0][2:0]  pct_split_num;
  logic             fetch_valid;
  logic             fetch_ready;
  logic [1:0]       fetch_warp_id;
  logic [31:0]      fetch_pc;
  logic [2:0]       fetch_split_num;
  logic             release_valid;
  logic [1:0]       release_warp_id;
  logic [3:0]       inflight;
  logic [31:0]      fetch_count;

  int n_vec = 0;
  int n_err = 0;

  gelato_fetch_scheduler #(
    .WARP_NUM        (4),
    .PC_WIDTH        (32),
    .SPLIT_NUM_WIDTH (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .pct_valid       (pct_valid),
    .pct_pc          (pct_pc),
    .pct_split_num   (pct_split_num),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .fetch_warp_id   (fetch_warp_id),
    .fetch_pc        (fetch_pc),
    .fetch_split_num (fetch_split_num),
    .release_valid   (release_valid),
    .release_warp_id (release_warp_id),
    .inflight        (inflight),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    rdy             = 1'b1;
    pct_valid       = '0;
    pct_pc          = '0;
    pct_split_num   = '0;
    fetch_ready     = 1'b0;
    release_valid   = 1'b0;
    release_warp_id = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    set_idle();

    // Reset state, then four warps issued back to back.
    do_reset();
    check("rst_valid", 64'(fetch_valid), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_pc", 64'(fetch_pc), 64'd0);
    pct_valid   = 4'b1111;
    pct_pc[0]   = 32'h100;
    pct_pc[1]   = 32'h200;
    pct_pc[2]   = 32'h300;
    pct_pc[3]   = 32'h400;
    fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_valid", 64'(fetch_valid), 64'd1);
      check("b2b_id", 64'(fetch_warp_id), 64'(i));
      check("b2b_pc", 64'(fetch_pc), 64'((i + 1) * 32'h100));
    end
    @(negedge clk);
    check("b2b_drain_valid", 64'(fetch_valid), 64'd0);
    check("b2b_inflight", 64'(inflight), 64'hf);
    check("b2b_count", 64'(fetch_count), 64'd4);

    // Backpressure holds the request stable while the PC table moves on.
    do_reset();
    pct_valid        = 4'b0100;
    pct_pc[2]        = 32'h2040;
    pct_split_num[2] = 3'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(fetch_valid), 64'd1);
      check("bp_pc", 64'(fetch_pc), 64'h2040);
      check("bp_split", 64'(fetch_split_num), 64'd5);
      if (i == 2) pct_pc[2] = 32'h3000;
    end
    check("bp_count_held", 64'(fetch_count), 64'd0);
    fetch_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_valid", 64'(fetch_valid), 64'd0);
    check("bp_count", 64'(fetch_count), 64'd1);

    // Release then re-issue of warp 1 with an updated PC.
    do_reset();
    pct_valid   = 4'b0010;
    pct_pc[1]   = 32'h1100;
    fetch_ready = 1'b1;
    @(negedge clk);
    check("rel_id", 64'(fetch_warp_id), 64'd1);
    check("rel_inflight_set", 64'(inflight), 64'b0010);
    @(negedge clk);
    check("rel_empty", 64'(fetch_valid), 64'd0);
    pct_pc[1]       = 32'h1104;
    release_valid   = 1'b1;
    release_warp_id = 2'd1;
    @(negedge clk);
    release_valid = 1'b0;
    check("rel_no_early_issue", 64'(fetch_valid), 64'd0);
    check("rel_inflight_clr", 64'(inflight), 64'b0000);
    @(negedge clk);
    check("rel_reissue_valid", 64'(fetch_valid), 64'd1);
    check("rel_reissue_pc", 64'(fetch_pc), 64'h1104);
    check("rel_inflight_reset", 64'(inflight), 64'b0010);

    // Fairness: every warp released the cycle after it fires.
    do_reset();
    pct_valid   = 4'b1111;
    fetch_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("rr_valid", 64'(fetch_valid), 64'd1);
      check("rr_id", 64'(fetch_warp_id), 64'(i % 4));
      release_valid   = (i > 0);
      release_warp_id = 2'((i + 3) % 4);
    end
    release_valid = 1'b0;

    // Stray release of a warp that is not in flight.
    do_reset();
    pct_valid   = 4'b0001;
    fetch_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stray_pre", 64'(inflight), 64'b0001);
    pct_valid       = 4'b0000;
    release_valid   = 1'b1;
    release_warp_id = 2'd3;
    @(negedge clk);
    release_valid = 1'b0;
    check("stray_inflight", 64'(inflight), 64'b0001);

    // Release naming warp 0 in the cycle it is selected, then an rdy=0 freeze.
    do_reset();
    pct_valid       = 4'b0001;
    release_valid   = 1'b1;
    release_warp_id = 2'd0;
    @(negedge clk);
    check("setwins_inflight", 64'(inflight), 64'b0001);
    check("setwins_valid", 64'(fetch_valid), 64'd1);
    rdy         = 1'b0;
    fetch_ready = 1'b1;
    pct_valid   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("frz_valid", 64'(fetch_valid), 64'd1);
      check("frz_id", 64'(fetch_warp_id), 64'd0);
      check("frz_count", 64'(fetch_count), 64'd0);
      check("frz_inflight", 64'(inflight), 64'b0001);
    end
    rdy           = 1'b1;
    release_valid = 1'b0;
    @(negedge clk);
    check("frz_after_count", 64'(fetch_count), 64'd1);
    check("frz_after_id", 64'(fetch_warp_id), 64'd1);

    // Asynchronous reset while holding a request with warps 0 and 2 in flight.
    do_reset();
    pct_valid = 4'b0101;
    @(negedge clk);
    fetch_ready = 1'b1;
    @(negedge clk);
    fetch_ready = 1'b0;
    check("arst_pre_inflight", 64'(inflight), 64'b0101);
    check("arst_pre_id", 64'(fetch_warp_id), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(fetch_valid), 64'd0);
    check("arst_inflight", 64'(inflight), 64'd0);
    @(negedge clk);
    rst         = 1'b0;
    fetch_ready = 1'b1;
    @(negedge clk);
    check("arst_first_valid", 64'(fetch_valid), 64'd1);
    check("arst_first_id", 64'(fetch_warp_id), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gelato_fetch_scheduler.md
Name: gelato_fetch_scheduler

Overview:
- Consumer end of the per-warp PC table interface. Each cycle it takes the per-warp valid/PC/split-table-number vectors from the split tables.
- Selects one eligible warp by round-robin and issues a registered fetch request to the instruction fetch stage using a valid/ready handshake.
- Tracks per-warp in-flight state so that a warp is not re-issued until decode reports its split/PC update.

Parameters:
- WARP_NUM, 4, number of warps. Power of two, at least 2.
- PC_WIDTH, 32, PC width in bits.
- SPLIT_NUM_WIDTH, 3, width of the split-table entry index carried with each PC.
- WARP_ID_WIDTH, $clog2(WARP_NUM), warp index width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- rdy  input  1  global enable; when low, all state holds
- pct_valid  input  WARP_NUM  per-warp "PC table entry valid" from the split tables
- pct_pc  input  WARP_NUM x PC_WIDTH  per-warp current PC
- pct_split_num  input  WARP_NUM x SPLIT_NUM_WIDTH  per-warp active split-table entry
- fetch_valid  output  1  fetch request valid
- fetch_ready  input  1  fetch stage accepts the request
- fetch_warp_id  output  WARP_ID_WIDTH  issued warp
- fetch_pc  output  PC_WIDTH  issued PC
- fetch_split_num  output  SPLIT_NUM_WIDTH  issued split-table entry
- release_valid  input  1  decode has applied the PC/split update for a warp
- release_warp_id  input  WARP_ID_WIDTH  warp being released
- inflight  output  WARP_NUM  per-warp in-flight mask (debug/visibility)
- fetch_count  output  32  number of accepted fetches

Behaviour:
- Reset (rst=1, asynchronous):
  - fetch_valid=0; fetch_warp_id, fetch_pc, fetch_split_num=0.
  - inflight=0; round-robin pointer rr_ptr=WARP_NUM-1, so warp 0 wins first; fetch_count=0.
- rdy=0: every register holds. fetch_valid stays asserted if it was set. Releases and handshakes occurring in this cycle are ignored; the upstream stages are frozen by the same rdy.
- Eligibility: elig[i] = pct_valid[i] & ~inflight[i]. It uses the registered inflight value, so a release becomes visible one cycle after release_valid.
- The output register is a two-state machine:
  - EMPTY (fetch_valid=0)
  - HOLD (fetch_valid=1)
- EMPTY -> HOLD when rdy and any elig[i]:
  - Winner = first eligible warp searching rr_ptr+1, rr_ptr+2, ... modulo WARP_NUM.
  - Latch pct_pc[w] and pct_split_num[w] into the outputs.
  - Set inflight[w]=1; rr_ptr <= w.
  - Latency from pct_valid to fetch_valid is 1 cycle.
- HOLD with fetch_ready=1 (fire): fetch_count increments, wrapping at 2^32.
  - If any warp is eligible in the same cycle, select the next winner as above and stay in HOLD. This gives back-to-back issue, one request per cycle.
  - Otherwise go to EMPTY.
- HOLD with fetch_ready=0: all fetch_* outputs hold stable. No new selection is made. pct_* changes are not sampled.
- Release:
  - release_valid clears inflight[release_warp_id] on the next edge.
  - A release for a warp whose inflight bit is 0 is ignored, with no other effect.
  - A release for the warp currently held unaccepted in the output register is legal. It clears the bit, and the held request is still delivered.
- Simultaneous set and clear of the same inflight bit in one cycle (warp selected while a release names it): the set wins.
- pct_valid[i] may drop while warp i is inflight. No action is taken; the warp stays masked until released.
- A warp whose pct_valid=0 is never selected, whatever rr_ptr is.
- Reset mid-HOLD: the request is dropped (fetch_valid=0 asynchronously) and all inflight bits are cleared.

Test Plan:
- Reset then pct_valid=4'b1111, PCs 0x100/0x200/0x300/0x400, fetch_ready=1, no releases:
  - Required: issues warps 0,1,2,3 on four consecutive cycles with matching PCs; then fetch_valid=0; inflight=4'b1111; fetch_count=4.
- Backpressure: warp 2 only valid (PC 0x2040, split 5), fetch_ready=0 for 5 cycles, PC changed to 0x3000 mid-hold:
  - Required: fetch_pc stays 0x2040 and fetch_split_num stays 5 for all 5 cycles; accepted on the 6th cycle; fetch_count=1.
- Release and re-issue: after warp 1 is issued, pulse release_valid with id 1 while pct_pc[1]=0x1104:
  - Required: warp 1 is re-issued with 0x1104 no earlier than 1 cycle after the release; inflight[1] goes 1->0->1.
- Fairness: all four warps always valid, release each warp the cycle after it fires:
  - Required: issue order 0,1,2,3,0,1,... over 16 fires with no warp repeated before the others.
- Corner cases:
  - A stray release of a non-inflight warp 3 leaves inflight unchanged.
  - A release of warp 0 in the same cycle warp 0 is selected leaves inflight[0]=1.
  - rdy=0 for 3 cycles during HOLD freezes fetch_count and all outputs.
- Assert rst asynchronously while in HOLD with inflight=4'b0101:
  - Required: fetch_valid=0 and inflight=0 immediately.
  - Required: after reset is released, warp 0 is selected first.
